// File: rtl/alu_reg_sequencer.sv
// alu_reg_sequencer
//   Operand/issue stage in front of a combinational K_ALU. Holds a REGS x N
//   register file, accepts one instruction at a time over valid/ready,
//   registers the ALU operands, captures alu_z one cycle later and writes it
//   back to rd. Only one instruction is ever in flight (4 cycles each).
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   instr_valid/instr_ready    instruction handshake (ready only in IDLE)
//   instr_cmd/rd/rs/rt         command, destination and source registers
//   imm_en, imm                immediate select and value for operand B
//   wr_en/wr_addr/wr_data      host preload write port (any state)
//   dbg_addr -> dbg_data       combinational register-file read
//   alu_a/alu_b/alu_cmd        registered operands/command to K_ALU
//   alu_z                      K_ALU result
//   result, done               last captured alu_z, one-cycle completion pulse
module alu_reg_sequencer #(
  parameter int N    = 6,
  parameter int REGS = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_cmd,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs,
  input  logic [AW-1:0] instr_rt,
  input  logic          imm_en,
  input  logic [N-1:0]  imm,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [N-1:0]  dbg_data,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [3:0]    alu_cmd,
  input  logic [N-1:0]  alu_z,
  output logic [N-1:0]  result,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_e;

  typedef struct packed {
    logic [3:0]    cmd;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          imm_en;
    logic [N-1:0]  imm;
  } instr_t;

  state_e                   state_q, state_d;
  instr_t                   ins_q, ins_d;
  logic [REGS-1:0][N-1:0]   rf_q, rf_d;
  logic [N-1:0]             alu_a_q, alu_a_d;
  logic [N-1:0]             alu_b_q, alu_b_d;
  logic [3:0]               alu_cmd_q, alu_cmd_d;
  logic [N-1:0]             result_q, result_d;

  always_comb begin
    state_d   = state_q;
    ins_d     = ins_q;
    rf_d      = rf_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_cmd_d = alu_cmd_q;
    result_d  = result_q;

    // Host write first so an EXEC writeback to the same address overrides it.
    if (wr_en) rf_d[wr_addr] = wr_data;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          ins_d.cmd    = instr_cmd;
          ins_d.rd     = instr_rd;
          ins_d.rs     = instr_rs;
          ins_d.rt     = instr_rt;
          ins_d.imm_en = imm_en;
          ins_d.imm    = imm;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        // Reads use rf_q, so a host write in this same cycle is not visible.
        alu_a_d   = rf_q[ins_q.rs];
        alu_b_d   = ins_q.imm_en ? ins_q.imm : rf_q[ins_q.rt];
        alu_cmd_d = ins_q.cmd;
        state_d   = EXEC;
      end
      EXEC: begin
        result_d          = alu_z;
        rf_d[ins_q.rd]    = alu_z;
        state_d           = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // R0 is hardwired to zero; any write aimed at it is dropped here.
    rf_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ins_q     <= '0;
      rf_q      <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_cmd_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      ins_q     <= ins_d;
      rf_q      <= rf_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_cmd_q <= alu_cmd_d;
      result_q  <= result_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign done        = (state_q == DONE);
  assign dbg_data    = rf_q[dbg_addr];
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_cmd     = alu_cmd_q;
  assign result      = result_q;

endmodule

// File: tb/tb_alu_reg_sequencer.sv
`timescale 1ns/1ps
// Bench for alu_reg_sequencer with an adder stub standing in for K_ALU.
// Expected values come from a register-array model updated with plain
// arithmetic; DUT outputs are sampled 1ns after the rising edge.
module tb_alu_reg_sequencer;
  localparam int N = 6, REGS = 8, AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid, instr_ready;
  logic [3:0]    instr_cmd;
  logic [AW-1:0] instr_rd, instr_rs, instr_rt;
  logic          imm_en;
  logic [N-1:0]  imm;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic [AW-1:0] dbg_addr;
  logic [N-1:0]  dbg_data, alu_a, alu_b, alu_z, result;
  logic [3:0]    alu_cmd;
  logic          done;

  int checks = 0, failures = 0;
  logic [N-1:0] ref_rf [REGS];

  alu_reg_sequencer #(.N(N), .REGS(REGS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_cmd(instr_cmd), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
    .imm_en(imm_en), .imm(imm), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cmd(alu_cmd), .alu_z(alu_z), .result(result), .done(done)
  );

  // K_ALU stub: Z = (A+B) mod 2^N
  assign alu_z = N'((int'(alu_a) + int'(alu_b)) % (1 << N));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [N-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    if (a != 0) ref_rf[a] = d;
  endtask

  function automatic logic [N-1:0] model_b(input logic [AW-1:0] rt, input logic ie,
                                           input logic [N-1:0] im);
    return ie ? im : ref_rf[rt];
  endfunction

  function automatic logic [N-1:0] model_z(input logic [N-1:0] a, input logic [N-1:0] b);
    return N'((int'(a) + int'(b)) % (1 << N));
  endfunction

  task automatic model_wb(input logic [AW-1:0] rd, input logic [N-1:0] z);
    if (rd != 0) ref_rf[rd] = z;
  endtask

  task automatic set_instr(input logic [3:0] cmd, input logic [AW-1:0] rd, rs, rt,
                           input logic ie, input logic [N-1:0] im);
    instr_cmd = cmd; instr_rd = rd; instr_rs = rs; instr_rt = rt; imm_en = ie; imm = im;
  endtask

  task automatic wait_ready();
    for (int t = 0; t < 20 && !instr_ready; t++) step();
  endtask

  // Issue one instruction and observe it. lat counts edges after the accept
  // edge until done is seen (-1 if never); rdy_low counts post-accept
  // samples with instr_ready low up to and including the done cycle.
  task automatic run_instr(input logic [3:0] cmd, input logic [AW-1:0] rd, rs, rt,
                           input logic ie, input logic [N-1:0] im,
                           output logic [N-1:0] oa, ob, output logic [3:0] oc,
                           output logic [N-1:0] ores, output int lat,
                           output int rdy_low, output logic rdy_after);
    set_instr(cmd, rd, rs, rt, ie, im);
    instr_valid = 1'b1;
    wait_ready();
    step();
    instr_valid = 1'b0;
    lat = -1; rdy_low = 0; oa = '0; ob = '0; oc = '0; ores = '0;
    for (int j = 0; j < 10 && lat < 0; j++) begin
      if (j > 0) step();
      if (!instr_ready) rdy_low++;
      if (j == 1) begin oa = alu_a; ob = alu_b; oc = alu_cmd; end
      if (done) begin lat = j; ores = result; end
    end
    step();
    rdy_after = instr_ready;
  endtask

  task automatic test_reset();
    logic [N-1:0] v;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if ({alu_a, alu_b, alu_cmd, result} !== '0) begin failures++;
      $display("FAIL reset_outputs: a=%0d b=%0d cmd=%0d res=%0d want all 0", alu_a, alu_b, alu_cmd, result); end
    for (int a = 0; a < REGS; a++) begin
      dbg_addr = AW'(a); #1;
      checks++; if (dbg_data !== '0) begin failures++; $display("FAIL reset_rf[%0d]: got %0d want 0", a, dbg_data); end
    end
    // Reset mid-EXEC: R1=5, instruction rd=2 would write 10.
    host_write(1, 6'd5);
    set_instr(4'd8, 3'd2, 3'd1, 3'd1, 1'b0, '0);
    instr_valid = 1'b1;
    wait_ready();
    step(); instr_valid = 1'b0;   // FETCH
    step();                       // EXEC
    rst_n = 1'b0; #1;
    checks++; if (instr_ready !== 1'b1 || done !== 1'b0) begin failures++;
      $display("FAIL midreset_state: ready=%b done=%b want 1/0", instr_ready, done); end
    dbg_addr = 3'd1; #1;
    checks++; if (dbg_data !== '0 || result !== '0) begin failures++;
      $display("FAIL midreset_clear: R1=%0d result=%0d want 0/0", dbg_data, result); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset_no_done: cycle %0d done=%b want 0", k, done); end
      step();
    end
    dbg_addr = 3'd2; #1; v = dbg_data;
    checks++; if (v !== '0 || result !== '0) begin failures++;
      $display("FAIL midreset_no_wb: R2=%0d result=%0d want 0/0", v, result); end
    for (int a = 0; a < REGS; a++) ref_rf[a] = '0;
  endtask

  task automatic test_basic();
    logic [N-1:0] oa, ob, ores, ea, eb, ez; logic [3:0] oc; int lat, rl; logic ra;
    host_write(1, 6'd5); host_write(2, 6'd3);
    ea = ref_rf[1]; eb = model_b(2, 0, '0); ez = model_z(ea, eb);
    run_instr(4'd8, 3'd3, 3'd1, 3'd2, 1'b0, '0, oa, ob, oc, ores, lat, rl, ra);
    model_wb(3, ez);
    checks++; if (oa !== ea || ob !== eb || oc !== 4'd8) begin failures++;
      $display("FAIL basic_operands: a=%0d b=%0d cmd=%0d want %0d %0d 8", oa, ob, oc, ea, eb); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL basic_latency: done %0d edges after accept want 2", lat); end
    checks++; if (ores !== ez) begin failures++; $display("FAIL basic_result: got %0d want %0d", ores, ez); end
    checks++; if (rl !== 3 || ra !== 1'b1) begin failures++;
      $display("FAIL basic_ready: low %0d cycles, after=%b want 3/1", rl, ra); end
    dbg_addr = 3'd3; #1;
    checks++; if (dbg_data !== ref_rf[3]) begin failures++; $display("FAIL basic_wb: R3=%0d want %0d", dbg_data, ref_rf[3]); end
  endtask

  task automatic test_imm_wrap();
    logic [N-1:0] oa, ob, ores, ez; logic [3:0] oc; int lat, rl; logic ra;
    host_write(1, 6'd60);
    ez = model_z(ref_rf[1], model_b(2, 1, 6'd7));
    run_instr(4'd2, 3'd4, 3'd1, 3'd2, 1'b1, 6'd7, oa, ob, oc, ores, lat, rl, ra);
    model_wb(4, ez);
    checks++; if (ob !== 6'd7 || oa !== 6'd60) begin failures++; $display("FAIL imm_operands: a=%0d b=%0d want 60 7", oa, ob); end
    checks++; if (ores !== ez) begin failures++; $display("FAIL imm_wrap_result: got %0d want %0d", ores, ez); end
    dbg_addr = 3'd4; #1;
    checks++; if (dbg_data !== ref_rf[4]) begin failures++; $display("FAIL imm_wb: R4=%0d want %0d", dbg_data, ref_rf[4]); end
  endtask

  task automatic test_r0();
    logic [N-1:0] oa, ob, ores, ez; logic [3:0] oc; int lat, rl; logic ra;
    host_write(1, 6'd5); host_write(2, 6'd3);
    ez = model_z(ref_rf[1], ref_rf[2]);
    run_instr(4'd8, 3'd0, 3'd1, 3'd2, 1'b0, '0, oa, ob, oc, ores, lat, rl, ra);
    checks++; if (ores !== ez) begin failures++; $display("FAIL r0_result: got %0d want %0d", ores, ez); end
    dbg_addr = 3'd0; #1;
    checks++; if (dbg_data !== '0) begin failures++; $display("FAIL r0_after_wb: got %0d want 0", dbg_data); end
    host_write(0, 6'd33);
    dbg_addr = 3'd0; #1;
    checks++; if (dbg_data !== '0) begin failures++; $display("FAIL r0_host_write: got %0d want 0", dbg_data); end
    for (int a = 1; a < REGS; a++) begin
      dbg_addr = AW'(a); #1;
      checks++; if (dbg_data !== ref_rf[a]) begin failures++; $display("FAIL r0_others[%0d]: got %0d want %0d", a, dbg_data, ref_rf[a]); end
    end
  endtask

  task automatic test_fetch_write();
    logic [N-1:0] ea, ez;
    host_write(1, 6'd10);
    ea = ref_rf[1]; ez = model_z(ea, ea);
    set_instr(4'd3, 3'd5, 3'd1, 3'd1, 1'b0, '0);
    instr_valid = 1'b1; wait_ready();
    step(); instr_valid = 1'b0;                     // FETCH
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 6'd20;
    step(); wr_en = 1'b0; ref_rf[1] = 6'd20;        // EXEC
    checks++; if (alu_a !== ea || alu_b !== ea) begin failures++;
      $display("FAIL fetch_write_operands: a=%0d b=%0d want %0d %0d", alu_a, alu_b, ea, ea); end
    step();                                          // DONE
    model_wb(5, ez);
    checks++; if (done !== 1'b1 || result !== ez) begin failures++;
      $display("FAIL fetch_write_result: done=%b result=%0d want 1 %0d", done, result, ez); end
    dbg_addr = 3'd1; #1;
    checks++; if (dbg_data !== 6'd20) begin failures++; $display("FAIL fetch_write_host: R1=%0d want 20", dbg_data); end
    step();
  endtask

  task automatic test_collision();
    logic [N-1:0] ez;
    host_write(1, 6'd5); host_write(2, 6'd3);
    ez = model_z(ref_rf[1], ref_rf[2]);
    set_instr(4'd8, 3'd3, 3'd1, 3'd2, 1'b0, '0);
    instr_valid = 1'b1; wait_ready();
    step(); instr_valid = 1'b0;   // FETCH
    step();                       // EXEC: host write lands on the EXEC-exit edge
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 6'd9;
    step(); wr_en = 1'b0;         // DONE
    ref_rf[3] = 6'd9; model_wb(3, ez);
    dbg_addr = 3'd3; #1;
    checks++; if (dbg_data !== ref_rf[3]) begin failures++; $display("FAIL collision: R3=%0d want %0d", dbg_data, ref_rf[3]); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL collision_done: got %b want 1", done); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] z1, e2a, e2b, z2; int j, rl, done_j;
    host_write(1, 6'd5); host_write(2, 6'd3);
    z1 = model_z(ref_rf[1], ref_rf[2]);
    set_instr(4'd8, 3'd3, 3'd1, 3'd2, 1'b0, '0);
    instr_valid = 1'b1; wait_ready();
    step();                                   // first accepted, valid stays high
    set_instr(4'd1, 3'd6, 3'd3, 3'd1, 1'b0, '0);
    j = 0; rl = 0; done_j = -1;
    while (!instr_ready && j < 10) begin
      rl++;
      if (done) done_j = j;
      step(); j++;
    end
    model_wb(3, z1);
    checks++; if (rl !== 3) begin failures++; $display("FAIL b2b_ready_low: got %0d cycles want 3", rl); end
    checks++; if (done_j !== 2) begin failures++; $display("FAIL b2b_first_done: at %0d want 2", done_j); end
    e2a = ref_rf[3]; e2b = ref_rf[1]; z2 = model_z(e2a, e2b);
    step(); instr_valid = 1'b0;               // second in FETCH
    step();                                   // EXEC
    checks++; if (alu_a !== e2a || alu_b !== e2b || alu_cmd !== 4'd1) begin failures++;
      $display("FAIL b2b_operands: a=%0d b=%0d cmd=%0d want %0d %0d 1", alu_a, alu_b, alu_cmd, e2a, e2b); end
    step();                                   // DONE
    model_wb(6, z2);
    checks++; if (done !== 1'b1 || result !== z2) begin failures++;
      $display("FAIL b2b_result: done=%b result=%0d want 1 %0d", done, result, z2); end
    step();
    dbg_addr = 3'd6; #1;
    checks++; if (dbg_data !== ref_rf[6]) begin failures++; $display("FAIL b2b_wb: R6=%0d want %0d", dbg_data, ref_rf[6]); end
  endtask

  task automatic test_random();
    logic [N-1:0] oa, ob, ores, ea, eb, ez, im; logic [3:0] oc, cmd; int lat, rl; logic ra, ie;
    logic [AW-1:0] rd, rs, rt;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(1, 0) == 1) host_write(AW'($urandom_range(REGS-1, 0)), N'($urandom));
      cmd = 4'($urandom); rd = AW'($urandom); rs = AW'($urandom); rt = AW'($urandom);
      ie = 1'($urandom); im = N'($urandom);
      ea = ref_rf[rs]; eb = model_b(rt, ie, im); ez = model_z(ea, eb);
      run_instr(cmd, rd, rs, rt, ie, im, oa, ob, oc, ores, lat, rl, ra);
      model_wb(rd, ez);
      checks++; if (oa !== ea || ob !== eb || oc !== cmd) begin failures++;
        $display("FAIL rand_operands[%0d]: a=%0d b=%0d cmd=%0d want %0d %0d %0d", it, oa, ob, oc, ea, eb, cmd); end
      checks++; if (ores !== ez || lat !== 2) begin failures++;
        $display("FAIL rand_result[%0d]: result=%0d lat=%0d want %0d 2", it, ores, lat, ez); end
    end
    for (int a = 0; a < REGS; a++) begin
      dbg_addr = AW'(a); #1;
      checks++; if (dbg_data !== ref_rf[a]) begin failures++; $display("FAIL rand_rf[%0d]: got %0d want %0d", a, dbg_data, ref_rf[a]); end
    end
  endtask

  initial begin
    instr_valid = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
    set_instr('0, '0, '0, '0, 1'b0, '0);
    for (int a = 0; a < REGS; a++) ref_rf[a] = '0;
    test_reset();
    test_basic();
    test_imm_wrap();
    test_r0();
    test_fetch_write();
    test_collision();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
